// File: rtl/flit_rx_assembler.sv
// Assembles MSB-first UART bytes into checksummed flits and queues good flits
// in a small first-word-fall-through FIFO with a registered head.
module flit_rx_assembler #(
   parameter int FLIT_WIDTH   = 128,
   parameter int DEPTH        = 2,
   parameter int BYTE_TIMEOUT = 17360
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            in_byte,
   input  logic                  in_valid,
   output logic [FLIT_WIDTH-1:0] out_flit,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  err_overflow,
   output logic                  err_checksum,
   output logic                  err_timeout,
   output logic [15:0]           good_count,
   output logic [15:0]           drop_count
);

   localparam int NB = FLIT_WIDTH / 8;
   localparam int IW = $clog2(NB);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(BYTE_TIMEOUT + 1);

   localparam logic [IW-1:0] LAST_IDX      = IW'(NB - 1);
   localparam logic [IW-1:0] LAST_WORD_IDX = IW'(NB - 3);
   localparam logic [TW-1:0] TIMEOUT_LAST  = TW'(BYTE_TIMEOUT - 1);
   localparam logic [CW-1:0] FULL_COUNT    = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      CHECK   = 2'd2
   } state_t;

   state_t                  state_reg, state_next;
   logic [IW-1:0]           idx_reg;
   logic [TW-1:0]           tcnt_reg;
   logic [15:0]             sum_reg;
   logic [FLIT_WIDTH-1:0]   shift_reg;

   logic                    start_flit, collect_byte, take_byte, add_word;
   logic                    timeout, checking, sum_ok;
   logic                    push, pop, full, drop_ovf, drop_cks;

   logic [FLIT_WIDTH-1:0]   mem [DEPTH];
   logic [AW-1:0]           wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]           count_reg;
   logic [FLIT_WIDTH-1:0]   out_flit_reg;
   logic [15:0]             good_count_reg, drop_count_reg;

   always_comb begin
      state_next   = state_reg;
      start_flit   = 1'b0;
      collect_byte = 1'b0;
      timeout      = 1'b0;
      checking     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               start_flit = 1'b1;
               state_next = COLLECT;
            end
         end
         COLLECT: begin
            if (in_valid) begin
               collect_byte = 1'b1;
               if (idx_reg == LAST_IDX)
                  state_next = CHECK;
            end else if (tcnt_reg == TIMEOUT_LAST) begin
               timeout    = 1'b1;
               state_next = IDLE;
            end
         end
         CHECK: begin
            checking = 1'b1;
            // A byte arriving during CHECK already belongs to the next flit.
            if (in_valid) begin
               start_flit = 1'b1;
               state_next = COLLECT;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign take_byte = start_flit | collect_byte;
   // Odd byte index below the checksum word closes a 16-bit data word.
   assign add_word  = collect_byte & idx_reg[0] & (idx_reg <= LAST_WORD_IDX);
   assign sum_ok    = (sum_reg == shift_reg[15:0]);
   assign full      = (count_reg == FULL_COUNT);
   assign pop       = out_valid & out_ready;
   assign push      = checking & sum_ok & (~full | pop);
   assign drop_ovf  = checking & sum_ok & full & ~pop;
   assign drop_cks  = checking & ~sum_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         tcnt_reg  <= '0;
         sum_reg   <= '0;
         shift_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (take_byte)
            shift_reg <= {shift_reg[FLIT_WIDTH-9:0], in_byte};
         if (start_flit) begin
            idx_reg  <= IW'(1);
            tcnt_reg <= '0;
            sum_reg  <= '0;
         end else if (collect_byte) begin
            idx_reg  <= idx_reg + 1'b1;
            tcnt_reg <= '0;
            if (add_word)
               sum_reg <= sum_reg + {shift_reg[7:0], in_byte};
         end else if (state_reg == COLLECT && !timeout) begin
            tcnt_reg <= tcnt_reg + 1'b1;
         end else begin
            idx_reg  <= '0;
            tcnt_reg <= '0;
            sum_reg  <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst)
         mem[wr_ptr_reg] <= shift_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         out_flit_reg <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         // Bypass the array when the pushed flit becomes the new head.
         if (push && (count_reg == CW'(0) || (count_reg == CW'(1) && pop)))
            out_flit_reg <= shift_reg;
         else if (pop)
            out_flit_reg <= mem[rd_ptr_reg + 1'b1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         good_count_reg <= '0;
         drop_count_reg <= '0;
      end else begin
         if (push && good_count_reg != 16'hFFFF)
            good_count_reg <= good_count_reg + 1'b1;
         if ((drop_ovf || drop_cks || timeout) && drop_count_reg != 16'hFFFF)
            drop_count_reg <= drop_count_reg + 1'b1;
      end
   end

   assign out_flit     = out_flit_reg;
   assign out_valid    = (count_reg != CW'(0));
   assign err_overflow = drop_ovf & ~rst;
   assign err_checksum = drop_cks & ~rst;
   assign err_timeout  = timeout & ~rst;
   assign good_count   = good_count_reg;
   assign drop_count   = drop_count_reg;

endmodule

// File: tb/tb_flit_rx_assembler.sv
// Directed bench for flit_rx_assembler: good, bad, overflow, timeout,
// back-to-back and mid-flit reset scenarios.
module tb_flit_rx_assembler;

   logic         clk;
   logic         rst;
   logic [7:0]   in_byte;
   logic         in_valid;
   logic [127:0] out_flit;
   logic         out_valid;
   logic         out_ready;
   logic         err_overflow;
   logic         err_checksum;
   logic         err_timeout;
   logic [15:0]  good_count;
   logic [15:0]  drop_count;

   int chk_cnt = 0;
   int err_cnt = 0;
   int n_cks = 0, n_ovf = 0, n_to = 0, n_multi = 0;
   logic [127:0] rx_q [$];

   localparam logic [127:0] G_FLIT   = 128'h0102030405060708090A0B0C0D0E3138;
   localparam logic [127:0] BAD_FLIT = 128'h0102030405060708090A0B0C0D0E3139;

   flit_rx_assembler #(
      .FLIT_WIDTH  (128),
      .DEPTH       (2),
      .BYTE_TIMEOUT(20)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_byte     (in_byte),
      .in_valid    (in_valid),
      .out_flit    (out_flit),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .err_overflow(err_overflow),
      .err_checksum(err_checksum),
      .err_timeout (err_timeout),
      .good_count  (good_count),
      .drop_count  (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (err_checksum) n_cks++;
         if (err_overflow) n_ovf++;
         if (err_timeout)  n_to++;
         if (int'(err_checksum) + int'(err_overflow) + int'(err_timeout) > 1) n_multi++;
         if (out_valid && out_ready) rx_q.push_back(out_flit);
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Returns in the CHECK cycle of the flit (one cycle after its last byte).
   task automatic send_flit(input logic [127:0] f);
      for (int i = 0; i < 16; i++) begin
         in_byte  = f[127-8*i -: 8];
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      #1;
   endtask

   function automatic logic [127:0] mk_flit(input logic [7:0] base);
      logic [127:0] f;
      logic [15:0]  s;
      f = '0;
      s = '0;
      for (int i = 0; i < 14; i++) f[127-8*i -: 8] = base + 8'(i * 7);
      for (int w = 0; w < 7; w++) s = s + f[127-16*w -: 16];
      f[15:0] = s;
      return f;
   endfunction

   initial begin
      logic [127:0] f1, f2, f3, f4, f5, f6;
      int n;
      f1 = mk_flit(8'h10);
      f2 = mk_flit(8'h40);
      f3 = mk_flit(8'h90);
      f4 = mk_flit(8'hC3);
      f5 = mk_flit(8'h21);
      f6 = mk_flit(8'hE7);

      rst       = 1'b1;
      in_valid  = 1'b1;
      in_byte   = 8'hA5;
      out_ready = 1'b1;
      tick(); tick(); tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_flit", out_flit, 0);
      check("rst_errs", {err_overflow, err_checksum, err_timeout}, 0);
      check("rst_good", good_count, 0);
      check("rst_drop", drop_count, 0);
      tick();
      check("rst_in_ignored", out_valid, 0);

      // Good flit, latency T+2
      send_flit(G_FLIT);
      check("good_chk_valid", out_valid, 0);
      check("good_chk_cks", err_checksum, 0);
      tick();
      check("good_valid", out_valid, 1);
      check("good_flit", out_flit, G_FLIT);
      check("good_count1", good_count, 1);
      tick();
      check("good_popped", out_valid, 0);

      // Bad checksum
      send_flit(BAD_FLIT);
      check("bad_cks_pulse", err_checksum, 1);
      check("bad_valid_chk", out_valid, 0);
      tick();
      check("bad_cks_end", err_checksum, 0);
      check("bad_valid", out_valid, 0);
      check("bad_drop", drop_count, 1);

      // Overflow with DEPTH=2
      out_ready = 1'b0;
      send_flit(f1);
      check("ovf_f1", err_overflow, 0);
      tick();
      send_flit(f2);
      check("ovf_f2", err_overflow, 0);
      tick();
      send_flit(f3);
      check("ovf_f3", err_overflow, 1);
      tick();
      check("ovf_drop", drop_count, 2);
      check("ovf_good", good_count, 3);
      tick(); tick();
      check("ovf_hold_valid", out_valid, 1);
      check("ovf_hold_flit", out_flit, f1);
      out_ready = 1'b1;
      #1;
      check("drain_1", out_flit, f1);
      tick();
      check("drain_2_valid", out_valid, 1);
      check("drain_2", out_flit, f2);
      tick();
      check("drain_empty", out_valid, 0);

      // Inter-byte timeout
      for (int i = 0; i < 5; i++) begin
         in_byte  = 8'(8'h50 + i);
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      #1;
      n = 1;
      while (!err_timeout && n < 40) begin
         tick();
         n++;
      end
      check("to_cycles", n, 20);
      tick();
      check("to_pulse_end", err_timeout, 0);
      check("to_drop", drop_count, 3);
      send_flit(f4);
      check("to_next_cks", err_checksum, 0);
      tick();
      check("to_next_valid", out_valid, 1);
      check("to_next_flit", out_flit, f4);
      check("to_next_good", good_count, 4);
      tick();

      // Back-to-back: byte 0 of f6 lands in CHECK of f5
      rx_q.delete();
      send_flit(f5);
      send_flit(f6);
      check("b2b_cks", err_checksum, 0);
      tick(); tick();
      check("b2b_count", rx_q.size(), 2);
      if (rx_q.size() >= 2) begin
         check("b2b_first", rx_q[0], f5);
         check("b2b_second", rx_q[1], f6);
      end
      check("b2b_good", good_count, 6);
      check("b2b_drop", drop_count, 3);

      // Reset on byte 7, then a good flit
      for (int i = 0; i < 7; i++) begin
         in_byte  = G_FLIT[127-8*i -: 8];
         in_valid = 1'b1;
         tick();
      end
      in_byte = G_FLIT[127-56 -: 8];
      rst     = 1'b1;
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      check("mrst_good0", good_count, 0);
      check("mrst_drop0", drop_count, 0);
      check("mrst_valid", out_valid, 0);
      tick();
      send_flit(G_FLIT);
      check("mrst_chk_cks", err_checksum, 0);
      tick();
      check("mrst_flit", out_flit, G_FLIT);
      check("mrst_good1", good_count, 1);
      check("mrst_drop", drop_count, 0);
      tick(); tick();

      check("pulses_cks", n_cks, 1);
      check("pulses_ovf", n_ovf, 1);
      check("pulses_to", n_to, 1);
      check("pulses_exclusive", n_multi, 0);

      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
      $finish;
   end

endmodule
